// File: rtl/tdm_demux_receiver.sv
// Receive side of the TDM serial link: a 1-bit MSB-first stream with a frame-sync
// marker is split into CHANNELS registered words of WIDTH bits. Each word has a valid pulse.
module tdm_demux_receiver #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sdata,
  input  logic                         sync,
  output logic [CHANNELS*WIDTH-1:0]    ch_data,
  output logic [CHANNELS-1:0]          ch_valid,
  output logic                         frame_done,
  output logic                         sync_err
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = $clog2(CHANNELS);
  localparam int SW = WIDTH - 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                      state_q,      state_d;
  logic [BW-1:0]               bit_cnt_q,    bit_cnt_d;
  logic [CW-1:0]               ch_cnt_q,     ch_cnt_d;
  logic [SW-1:0]               shift_q,      shift_d;
  logic [CHANNELS*WIDTH-1:0]   ch_data_q,    ch_data_d;
  logic [CHANNELS-1:0]         ch_valid_q,   ch_valid_d;
  logic                        frame_done_q, frame_done_d;
  logic                        sync_err_q,   sync_err_d;
  logic [WIDTH-1:0]            word_s;

  assign word_s = {shift_q, sdata};

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      shift_q      <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      shift_q      <= shift_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    shift_d      = shift_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (sync) begin
          shift_d   = SW'(sdata);
          bit_cnt_d = BW'(1);
          ch_cnt_d  = '0;
          state_d   = SHIFT;
        end else begin
          state_d = HUNT;
        end
      end

      SHIFT: begin
        if (sync) begin
          // Any sync inside a frame restarts it; the partial word is simply dropped.
          sync_err_d = (bit_cnt_q != '0) || (ch_cnt_q != '0);
          shift_d    = SW'(sdata);
          bit_cnt_d  = BW'(1);
          ch_cnt_d   = '0;
          state_d    = SHIFT;
        end else if (bit_cnt_q == LAST_BIT) begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (ch_cnt_q == CW'(k)) begin
              ch_data_d[k*WIDTH +: WIDTH] = word_s;
              ch_valid_d[k]               = 1'b1;
            end else begin
              ch_valid_d[k] = 1'b0;
            end
          end
          bit_cnt_d = '0;
          if (ch_cnt_q == LAST_CH) begin
            frame_done_d = 1'b1;
            ch_cnt_d     = '0;
            state_d      = HUNT;
          end else begin
            ch_cnt_d = ch_cnt_q + CW'(1);
          end
        end else begin
          shift_d   = word_s[SW-1:0];
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d   = HUNT;
        bit_cnt_d = '0;
        ch_cnt_d  = '0;
      end
    endcase
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_receiver.sv
// Scoreboard bench for tdm_demux_receiver (CHANNELS=4, WIDTH=8): expected words and
// sync errors are queued as bits are driven and matched when the DUT pulses them.
module tb_tdm_demux_receiver;

  logic        clk;
  logic        rst;
  logic        sdata;
  logic        sync;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic        sync_err;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       fdone;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   errs = 0;
  exp_t mon_e;
  int   mon_c;

  tdm_demux_receiver #(.CHANNELS(4), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sdata      (sdata),
    .sync       (sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (!rst) begin
      if (ch_valid != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check_eq("unexp_valid", 64'(ch_valid), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("valid",  64'(ch_valid), 64'(4'b0001 << mon_e.ch));
          check_eq("data",   64'(ch_data[mon_e.ch*8 +: 8]), 64'(mon_e.data));
          check_eq("fdone",  64'(frame_done), 64'(mon_e.fdone));
          check_eq("vcycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (frame_done) begin
        check_eq("fdone_alone", 64'(frame_done), 64'd0);
      end
      if (sync_err) begin
        if (err_q.size() == 0) begin
          check_eq("unexp_err", 64'(sync_err), 64'd0);
        end else begin
          mon_c = err_q.pop_front();
          check_eq("err_cycle", 64'(cyc), 64'(mon_c));
        end
      end
    end
  end

  task automatic send_bit(input logic s, input logic d);
    sync  = s;
    sdata = d;
    @(negedge clk);
  endtask

  task automatic send_word(input int ch, input logic [7:0] w, input bit with_sync, input bit last);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        e.ch    = ch;
        e.data  = w;
        e.fdone = last;
        e.cyc   = cyc + 1;
        sb_q.push_back(e);
      end
      send_bit(with_sync && (i == 7), w[i]);
    end
  endtask

  task automatic send_frame(input logic [31:0] words);
    for (int ch = 0; ch < 4; ch++) begin
      send_word(ch, words[ch*8 +: 8], ch == 0, ch == 3);
    end
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_sb"},  64'(sb_q.size()), 64'd0);
    check_eq({tag, "_err"}, 64'(err_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] partial;
    rst   = 1'b1;
    sync  = 1'b0;
    sdata = 1'b0;
    #1;
    check_eq("reset_out", {26'd0, ch_data, ch_valid, frame_done, sync_err}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // No sync: everything stays zero
    for (int i = 0; i < 100; i++) begin
      send_bit(1'b0, 1'(i & 1));
      check_eq("nosync_out", {26'd0, ch_data, ch_valid, frame_done, sync_err}, 64'd0);
    end

    // Single frame
    send_frame(32'h00_FF_3C_A5);
    send_bit(1'b0, 1'b0);
    check_eq("single_data", 64'(ch_data), 64'h00FF3CA5);
    check_drained("single");

    // Back-to-back frames
    send_frame(32'h44_33_22_11);
    send_frame(32'h88_77_66_55);
    check_eq("b2b_data", 64'(ch_data), 64'h88776655);
    send_bit(1'b0, 1'b1);
    check_drained("b2b");

    // Mid-frame resync after channel 0 plus three bits of channel 1
    send_word(0, 8'hA5, 1'b1, 1'b0);
    partial = 8'hC3;
    for (int i = 7; i >= 5; i--) send_bit(1'b0, partial[i]);
    err_q.push_back(cyc + 1);
    send_frame(32'h04_03_02_01);
    check_eq("resync_data", 64'(ch_data), 64'h04030201);
    send_bit(1'b0, 1'b0);
    check_drained("resync");

    // Resync exactly on a word boundary inside a frame
    send_word(0, 8'h5A, 1'b1, 1'b0);
    err_q.push_back(cyc + 1);
    send_frame(32'h0D_0C_0B_0A);
    check_eq("bound_data", 64'(ch_data), 64'h0D0C0B0A);
    send_bit(1'b0, 1'b0);
    check_drained("bound");

    // Reset during channel 2
    send_word(0, 8'h12, 1'b1, 1'b0);
    send_word(1, 8'h34, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_out", {26'd0, ch_data, ch_valid, frame_done, sync_err}, 64'd0);
    @(negedge clk);
    check_eq("rst_hold_out", {26'd0, ch_data, ch_valid, frame_done, sync_err}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'b0, 1'b1);
    check_eq("hunt_after_rst", {26'd0, ch_data, ch_valid, frame_done, sync_err}, 64'd0);
    send_frame(32'hEF_BE_AD_DE);
    check_eq("clean_data", 64'(ch_data), 64'hEFBEADDE);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check_drained("rstmid");

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/tdm_demux_receiver.md
# tdm_demux_receiver

Receive end of the time-division-multiplexed serial link. Takes the 1-bit serial stream and its frame-sync marker, then demultiplexes the bits into CHANNELS parallel words of WIDTH bits each. Each word is held in a per-channel output register and strobed with a one-cycle valid pulse. The block sits after the link's mux-based serializer and feeds the per-channel consumers.

## Interface
- CHANNELS, default 4: number of time slots per frame, ≥2.
- WIDTH, default 8: bits per channel word, ≥2.
- clk  input  1  single clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sdata  input  1  serial data, sent MSB first, one bit per clk.
- sync  input  1  high for exactly the cycle that carries bit MSB of channel 0.
- ch_data  output  CHANNELS*WIDTH  per-channel registered words; channel k occupies [k*WIDTH +: WIDTH].
- ch_valid  output  CHANNELS  bit k pulses high for one cycle when ch_data slice k is updated.
- frame_done  output  1  one-cycle pulse when the last channel of a frame is updated.
- sync_err  output  1  one-cycle pulse when sync arrives mid-frame.

## Operation
- State machine states:
  - HUNT: waiting for the first sync.
  - SHIFT: receiving a frame.
- Internal registers:
  - bit_cnt: 0..WIDTH-1.
  - ch_cnt: 0..CHANNELS-1.
  - shift_reg: WIDTH-1 bits.
- HUNT:
  - sdata is ignored while sync=0.
  - On sync=1, sample sdata as bit MSB of channel 0, then set bit_cnt=1, ch_cnt=0 and go to SHIFT.
- SHIFT, normal bit: shift_reg <= {shift_reg, sdata}, then bit_cnt++.
- SHIFT, last bit of a word (bit_cnt==WIDTH-1):
  - ch_data[ch_cnt] <= {shift_reg, sdata}.
  - ch_valid[ch_cnt] pulses.
  - bit_cnt wraps to 0 and ch_cnt++.
- Last bit of the last channel:
  - frame_done pulses, in the same cycle as ch_valid[CHANNELS-1].
  - ch_cnt wraps to 0.
  - Next state is HUNT.
- Back-to-back frames:
  - A sync on the cycle immediately after a frame's last bit is handled by the HUNT rule.
  - This gives gapless operation; no cycle is lost.
- Sync mid-frame: sync=1 in SHIFT while (bit_cnt,ch_cnt)≠(0,0).
  - sync_err pulses.
  - The partial word is discarded and no ch_valid is raised for it.
  - The current sdata becomes bit MSB of channel 0; bit_cnt=1, ch_cnt=0; state stays SHIFT.
  - Channels already completed in the aborted frame keep their new values.
- Sync at a word boundary that is not a frame boundary is also treated as mid-frame.
- ch_data slices hold their value until overwritten by a completed word of the same channel; there is no clearing between frames.
- Only one ch_valid bit can be high in any cycle.

## Timing
- Reset (asynchronous, immediate):
  - state=HUNT, bit_cnt=0, ch_cnt=0, shift_reg=0.
  - ch_data=0, ch_valid=0, frame_done=0, sync_err=0.
- Reset asserted mid-frame aborts the frame silently: no sync_err and no valid pulses. After release the block waits in HUNT.
- Latency: the word for channel k appears on ch_data, with ch_valid[k]=1, in the cycle after the rising edge that samples its LSB. That is registered output with 1-cycle latency from the LSB bit time.
- Frame length is CHANNELS*WIDTH clk cycles, measured from the sync cycle to the frame_done edge inclusive.
- ch_valid, frame_done and sync_err are registered pulses, exactly one cycle wide.
- sync_err is asserted the cycle after the offending sync, together with any completed-word valid. None is possible at that edge because the word was discarded.

## Test plan
- Reset then single frame:
  - Stimulus: CHANNELS=4, WIDTH=8; sync on bit 0; bytes A5,3C,FF,00 sent MSB first.
  - Response: ch_valid pulses 0001, 0010, 0100, 1000 at cycles 8, 16, 24 and 32 after sync; ch_data=00_FF_3C_A5; frame_done with the last pulse.
- Back-to-back frames:
  - Stimulus: frame 11,22,33,44 followed with no gap by frame 55,66,77,88.
  - Response: 8 valid pulses, two frame_done pulses 32 cycles apart; final ch_data=88_77_66_55.
- Mid-frame resync:
  - Stimulus: after channel 0 (=A5) plus 3 bits of channel 1, assert sync and send a full frame 01,02,03,04.
  - Response: sync_err pulses once; no valid for the partial channel 1; the new frame completes normally.
- No sync:
  - Stimulus: toggle sdata for 100 cycles with sync=0 after reset.
  - Response: every output stays 0.
- Reset mid-frame:
  - Stimulus: assert rst during channel 2 of a frame, release, then send a clean frame DE,AD,BE,EF.
  - Response: all outputs 0 immediately on rst, no sync_err; the clean frame yields ch_data=EF_BE_AD_DE.
